// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: decodes a MIPS instruction into ALU operands and aluop,
// resolves EX/MEM and MEM/WB forwarding, and inserts one bubble per load-use hazard.
module id_ex_stage #(
    parameter int WIDTH = 32,
    parameter int RA    = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [WIDTH-1:0] in_rs_data,
    input  logic [WIDTH-1:0] in_rt_data,
    input  logic             fwd_em_we,
    input  logic [RA-1:0]    fwd_em_addr,
    input  logic [WIDTH-1:0] fwd_em_data,
    input  logic             fwd_mw_we,
    input  logic [RA-1:0]    fwd_mw_addr,
    input  logic [WIDTH-1:0] fwd_mw_data,
    input  logic             stall,
    input  logic             flush,
    output logic             out_valid,
    output logic [WIDTH-1:0] data1,
    output logic [WIDTH-1:0] data2,
    output logic [3:0]       aluop,
    output logic [WIDTH-1:0] out_store_data,
    output logic [RA-1:0]    out_dest,
    output logic             out_reg_write,
    output logic             out_mem_read,
    output logic             out_mem_write,
    output logic             out_illegal
);

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_XOR = 4'b0100;
    localparam logic [3:0] ALU_SLT = 4'b0101;
    localparam logic [3:0] ALU_LUI = 4'b0110;
    localparam logic [3:0] ALU_SHL = 4'b0111;
    localparam logic [3:0] ALU_SHR = 4'b1000;

    logic [5:0]       op, funct;
    logic [RA-1:0]    rs, rt, rd;
    logic [4:0]       shamt;
    logic [15:0]      imm;
    logic [WIDTH-1:0] imm_sext, imm_zext;
    logic [WIDTH-1:0] rs_fwd, rt_fwd;

    assign op       = in_instr[31:26];
    assign rs       = RA'(in_instr[25:21]);
    assign rt       = RA'(in_instr[20:16]);
    assign rd       = RA'(in_instr[15:11]);
    assign shamt    = in_instr[10:6];
    assign funct    = in_instr[5:0];
    assign imm      = in_instr[15:0];
    assign imm_sext = {{(WIDTH-16){imm[15]}}, imm};
    assign imm_zext = {{(WIDTH-16){1'b0}}, imm};

    // Youngest producer wins; register 0 is hardwired to zero.
    always_comb begin
        rs_fwd = in_rs_data;
        if (rs == '0)
            rs_fwd = '0;
        else if (fwd_em_we && fwd_em_addr == rs)
            rs_fwd = fwd_em_data;
        else if (fwd_mw_we && fwd_mw_addr == rs)
            rs_fwd = fwd_mw_data;
    end

    always_comb begin
        rt_fwd = in_rt_data;
        if (rt == '0)
            rt_fwd = '0;
        else if (fwd_em_we && fwd_em_addr == rt)
            rt_fwd = fwd_em_data;
        else if (fwd_mw_we && fwd_mw_addr == rt)
            rt_fwd = fwd_mw_data;
    end

    logic [WIDTH-1:0] dec_d1, dec_d2;
    logic [3:0]       dec_aluop;
    logic [RA-1:0]    dec_dest;
    logic             dec_wr, dec_mr, dec_mw, dec_ill;
    logic             reads_rs, reads_rt;

    always_comb begin
        dec_d1    = rs_fwd;
        dec_d2    = rt_fwd;
        dec_aluop = ALU_ADD;
        dec_dest  = '0;
        dec_wr    = 1'b0;
        dec_mr    = 1'b0;
        dec_mw    = 1'b0;
        dec_ill   = 1'b0;
        reads_rs  = 1'b1;
        reads_rt  = 1'b0;
        case (op)
            6'h00: begin
                reads_rt = 1'b1;
                dec_dest = rd;
                dec_wr   = 1'b1;
                case (funct)
                    6'h20, 6'h21: dec_aluop = ALU_ADD;
                    6'h22, 6'h23: dec_aluop = ALU_SUB;
                    6'h24:        dec_aluop = ALU_AND;
                    6'h25:        dec_aluop = ALU_OR;
                    6'h26:        dec_aluop = ALU_XOR;
                    6'h2A:        dec_aluop = ALU_SLT;
                    6'h04:        dec_aluop = ALU_SHL;
                    6'h06:        dec_aluop = ALU_SHR;
                    6'h00, 6'h02: begin
                        dec_aluop = (funct == 6'h00) ? ALU_SHL : ALU_SHR;
                        dec_d1    = WIDTH'(shamt);
                        reads_rs  = 1'b0;
                    end
                    default: begin
                        dec_ill  = 1'b1;
                        dec_wr   = 1'b0;
                        dec_dest = '0;
                    end
                endcase
            end
            6'h08, 6'h09: begin
                dec_d2 = imm_sext; dec_dest = rt; dec_wr = 1'b1;
            end
            6'h0A: begin
                dec_aluop = ALU_SLT; dec_d2 = imm_sext; dec_dest = rt; dec_wr = 1'b1;
            end
            6'h0C, 6'h0D, 6'h0E: begin
                dec_aluop = (op == 6'h0C) ? ALU_AND : (op == 6'h0D) ? ALU_OR : ALU_XOR;
                dec_d2    = imm_zext; dec_dest = rt; dec_wr = 1'b1;
            end
            6'h0F: begin
                dec_aluop = ALU_LUI; dec_d2 = imm_zext; dec_dest = rt; dec_wr = 1'b1;
                reads_rs  = 1'b0;
            end
            6'h23: begin
                dec_d2 = imm_sext; dec_dest = rt; dec_wr = 1'b1; dec_mr = 1'b1;
            end
            6'h2B: begin
                dec_d2 = imm_sext; dec_dest = rt; dec_mw = 1'b1; reads_rt = 1'b1;
            end
            default: dec_ill = 1'b1;
        endcase
    end

    logic hazard, load, bubble;

    assign hazard = in_valid && out_valid && out_mem_read && (out_dest != '0) &&
                    ((reads_rs && rs == out_dest) || (reads_rt && rt == out_dest));
    assign in_ready = !stall && !hazard;
    assign bubble   = flush || (!stall && (hazard || !in_valid));
    assign load     = !flush && !stall && !hazard && in_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst || bubble) begin
            out_valid      <= 1'b0;
            data1          <= '0;
            data2          <= '0;
            aluop          <= '0;
            out_store_data <= '0;
            out_dest       <= '0;
            out_reg_write  <= 1'b0;
            out_mem_read   <= 1'b0;
            out_mem_write  <= 1'b0;
            out_illegal    <= 1'b0;
        end else if (load) begin
            out_valid      <= 1'b1;
            data1          <= dec_d1;
            data2          <= dec_d2;
            aluop          <= dec_aluop;
            out_store_data <= rt_fwd;
            out_dest       <= dec_dest;
            out_reg_write  <= dec_wr && (dec_dest != '0);
            out_mem_read   <= dec_mr;
            out_mem_write  <= dec_mw;
            out_illegal    <= dec_ill;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed vector table, hand-written hazard/stall/flush/reset
// sequences, then randomized traffic checked against a behavioural model.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [31:0] in_instr, in_rs_data, in_rt_data;
    logic        fwd_em_we, fwd_mw_we;
    logic [4:0]  fwd_em_addr, fwd_mw_addr;
    logic [31:0] fwd_em_data, fwd_mw_data;
    logic        stall, flush;
    logic        out_valid;
    logic [31:0] data1, data2, out_store_data;
    logic [3:0]  aluop;
    logic [4:0]  out_dest;
    logic        out_reg_write, out_mem_read, out_mem_write, out_illegal;

    always #5 clk = ~clk;

    id_ex_stage #(.WIDTH(32), .RA(5)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .in_rs_data(in_rs_data), .in_rt_data(in_rt_data),
        .fwd_em_we(fwd_em_we), .fwd_em_addr(fwd_em_addr), .fwd_em_data(fwd_em_data),
        .fwd_mw_we(fwd_mw_we), .fwd_mw_addr(fwd_mw_addr), .fwd_mw_data(fwd_mw_data),
        .stall(stall), .flush(flush),
        .out_valid(out_valid), .data1(data1), .data2(data2), .aluop(aluop),
        .out_store_data(out_store_data), .out_dest(out_dest),
        .out_reg_write(out_reg_write), .out_mem_read(out_mem_read),
        .out_mem_write(out_mem_write), .out_illegal(out_illegal)
    );

    typedef struct packed {
        logic        valid;
        logic [31:0] d1, d2;
        logic [3:0]  op;
        logic [31:0] store;
        logic [4:0]  dest;
        logic        rw, mr, mw, ill;
    } exp_t;

    typedef struct {
        string       name;
        logic [31:0] ins, rsd, rtd;
        logic        ew;  logic [4:0] ea; logic [31:0] ed;
        logic        mw;  logic [4:0] ma; logic [31:0] md;
        exp_t        e;
    } vec_t;

    int n_vec = 0, n_err = 0;
    vec_t tbl[$];
    exp_t held;

    logic [5:0] r_fn [0:12] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26,
                                6'h2A, 6'h04, 6'h06, 6'h00, 6'h02, 6'h3F};
    logic [5:0] i_op [0:10] = '{6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h0F,
                                6'h23, 6'h2B, 6'h23, 6'h3F};

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic exp_t dut_out();
        return {out_valid, data1, data2, aluop, out_store_data, out_dest,
                out_reg_write, out_mem_read, out_mem_write, out_illegal};
    endfunction

    function automatic logic [31:0] r_ins(input int rs, rt, rd, sh, input logic [5:0] fn);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sh), fn};
    endfunction

    function automatic logic [31:0] i_ins(input logic [5:0] op, input int rs, rt,
                                          input logic [15:0] imm);
        return {op, 5'(rs), 5'(rt), imm};
    endfunction

    function automatic exp_t ex(input logic [31:0] d1, d2, input logic [3:0] op,
                                input logic [31:0] st, input int dest,
                                input logic rw, mr, mw, ill);
        return {1'b1, d1, d2, op, st, 5'(dest), rw, mr, mw, ill};
    endfunction

    function automatic vec_t mkv(input string nm, input logic [31:0] ins, rsd, rtd,
                                 input logic ew, input int ea, input logic [31:0] ed,
                                 input logic mw, input int ma, input logic [31:0] md,
                                 input exp_t e);
        vec_t v;
        v.name = nm; v.ins = ins; v.rsd = rsd; v.rtd = rtd;
        v.ew = ew; v.ea = 5'(ea); v.ed = ed; v.mw = mw; v.ma = 5'(ma); v.md = md; v.e = e;
        return v;
    endfunction

    // Register value as the ALU should see it after forwarding.
    function automatic logic [31:0] reg_val(input logic [4:0] r, input logic [31:0] rf);
        if (r == 0) return 0;
        if (fwd_em_we && fwd_em_addr == r) return fwd_em_data;
        if (fwd_mw_we && fwd_mw_addr == r) return fwd_mw_data;
        return rf;
    endfunction

    function automatic logic uses_rs(input logic [31:0] ins);
        if (ins[31:26] == 6'h0F) return 1'b0;
        if (ins[31:26] == 6'h00 && (ins[5:0] == 6'h00 || ins[5:0] == 6'h02)) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic uses_rt(input logic [31:0] ins);
        return ins[31:26] == 6'h00 || ins[31:26] == 6'h2B;
    endfunction

    // Expected registered result of accepting the currently driven instruction.
    function automatic exp_t ref_decode();
        exp_t e;
        logic [31:0] a, b, sx, zx;
        logic [4:0]  rt, rd;
        logic        wr;
        a  = reg_val(in_instr[25:21], in_rs_data);
        b  = reg_val(in_instr[20:16], in_rt_data);
        rt = in_instr[20:16];
        rd = in_instr[15:11];
        sx = {{16{in_instr[15]}}, in_instr[15:0]};
        zx = {16'h0, in_instr[15:0]};
        e = '0; e.valid = 1'b1; e.d1 = a; e.d2 = b; e.store = b;
        wr = 1'b1;
        if (in_instr[31:26] == 6'h00) begin
            e.dest = rd;
            case (in_instr[5:0])
                6'h20, 6'h21: e.op = 4'd0;
                6'h22, 6'h23: e.op = 4'd1;
                6'h24: e.op = 4'd2;
                6'h25: e.op = 4'd3;
                6'h26: e.op = 4'd4;
                6'h2A: e.op = 4'd5;
                6'h04: e.op = 4'd7;
                6'h06: e.op = 4'd8;
                6'h00: begin e.op = 4'd7; e.d1 = {27'd0, in_instr[10:6]}; end
                6'h02: begin e.op = 4'd8; e.d1 = {27'd0, in_instr[10:6]}; end
                default: begin e.ill = 1'b1; wr = 1'b0; e.dest = 0; end
            endcase
        end else begin
            e.dest = rt;
            case (in_instr[31:26])
                6'h08, 6'h09: e.d2 = sx;
                6'h0A: begin e.op = 4'd5; e.d2 = sx; end
                6'h0C: begin e.op = 4'd2; e.d2 = zx; end
                6'h0D: begin e.op = 4'd3; e.d2 = zx; end
                6'h0E: begin e.op = 4'd4; e.d2 = zx; end
                6'h0F: begin e.op = 4'd6; e.d2 = zx; end
                6'h23: begin e.d2 = sx; e.mr = 1'b1; end
                6'h2B: begin e.d2 = sx; e.mw = 1'b1; wr = 1'b0; end
                default: begin e.ill = 1'b1; wr = 1'b0; e.dest = 0; end
            endcase
        end
        e.rw = wr && e.dest != 0;
        return e;
    endfunction

    task automatic drive(input logic v, input logic [31:0] ins, rsd, rtd);
        in_valid = v; in_instr = ins; in_rs_data = rsd; in_rt_data = rtd;
    endtask

    task automatic set_fwd(input logic ew, input int ea, input logic [31:0] ed,
                           input logic mw, input int ma, input logic [31:0] md);
        fwd_em_we = ew; fwd_em_addr = 5'(ea); fwd_em_data = ed;
        fwd_mw_we = mw; fwd_mw_addr = 5'(ma); fwd_mw_data = md;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        exp_t e_hold;
        logic hz;
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 32'h0);
        set_fwd(0, 0, 0, 0, 0, 0);

        tbl.push_back(mkv("addi", i_ins(6'h08, 1, 2, 16'hFFFF), 32'h5, 32'h77, 0, 0, 0, 0, 0, 0,
                          ex(32'h5, 32'hFFFFFFFF, 4'd0, 32'h77, 2, 1, 0, 0, 0)));
        tbl.push_back(mkv("sll", r_ins(0, 2, 3, 4, 6'h00), 32'h9, 32'h1, 0, 0, 0, 0, 0, 0,
                          ex(32'h4, 32'h1, 4'd7, 32'h1, 3, 1, 0, 0, 0)));
        tbl.push_back(mkv("lui", i_ins(6'h0F, 0, 4, 16'h1234), 32'h0, 32'h0, 0, 0, 0, 0, 0, 0,
                          ex(32'h0, 32'h1234, 4'd6, 32'h0, 4, 1, 0, 0, 0)));
        tbl.push_back(mkv("fwd_em_beats_mw", r_ins(4, 0, 1, 0, 6'h20), 32'h1111, 32'h0,
                          1, 4, 32'hAAAA, 1, 4, 32'hBBBB,
                          ex(32'hAAAA, 32'h0, 4'd0, 32'h0, 1, 1, 0, 0, 0)));
        tbl.push_back(mkv("fwd_r0", r_ins(0, 0, 1, 0, 6'h20), 32'h1234, 32'h5678,
                          1, 0, 32'hAAAA, 1, 0, 32'hBBBB,
                          ex(32'h0, 32'h0, 4'd0, 32'h0, 1, 1, 0, 0, 0)));
        tbl.push_back(mkv("fwd_mw_sub", r_ins(4, 6, 5, 0, 6'h22), 32'h1, 32'h10,
                          1, 3, 32'hCCCC, 1, 4, 32'hBBBB,
                          ex(32'hBBBB, 32'h10, 4'd1, 32'h10, 5, 1, 0, 0, 0)));
        tbl.push_back(mkv("and_we0", r_ins(2, 3, 7, 0, 6'h24), 32'hF0, 32'h0F,
                          0, 2, 32'hDEAD, 0, 3, 32'hBEEF,
                          ex(32'hF0, 32'h0F, 4'd2, 32'h0F, 7, 1, 0, 0, 0)));
        tbl.push_back(mkv("slti", i_ins(6'h0A, 9, 8, 16'h8000), 32'h3, 32'h0, 0, 0, 0, 0, 0, 0,
                          ex(32'h3, 32'hFFFF8000, 4'd5, 32'h0, 8, 1, 0, 0, 0)));
        tbl.push_back(mkv("ori", i_ins(6'h0D, 11, 10, 16'h8000), 32'h1, 32'h2, 0, 0, 0, 0, 0, 0,
                          ex(32'h1, 32'h00008000, 4'd3, 32'h2, 10, 1, 0, 0, 0)));
        tbl.push_back(mkv("xori", i_ins(6'h0E, 3, 2, 16'hFFFF), 32'hF, 32'h0, 0, 0, 0, 0, 0, 0,
                          ex(32'hF, 32'h0000FFFF, 4'd4, 32'h0, 2, 1, 0, 0, 0)));
        tbl.push_back(mkv("lw", i_ins(6'h23, 1, 5, 16'h0004), 32'h100, 32'h0, 0, 0, 0, 0, 0, 0,
                          ex(32'h100, 32'h4, 4'd0, 32'h0, 5, 1, 1, 0, 0)));
        tbl.push_back(mkv("sw", i_ins(6'h2B, 1, 6, 16'hFFFC), 32'h200, 32'hCAFE, 0, 0, 0, 0, 0, 0,
                          ex(32'h200, 32'hFFFFFFFC, 4'd0, 32'hCAFE, 6, 0, 0, 1, 0)));
        tbl.push_back(mkv("illegal_op", i_ins(6'h3F, 1, 2, 16'h0), 32'h9, 32'h8, 0, 0, 0, 0, 0, 0,
                          ex(32'h9, 32'h8, 4'd0, 32'h8, 0, 0, 0, 0, 1)));
        tbl.push_back(mkv("illegal_funct", r_ins(1, 2, 3, 0, 6'h3F), 32'h9, 32'h8, 0, 0, 0, 0, 0, 0,
                          ex(32'h9, 32'h8, 4'd0, 32'h8, 0, 0, 0, 0, 1)));
        tbl.push_back(mkv("addi_r0", i_ins(6'h09, 1, 0, 16'h0001), 32'h2, 32'h0, 0, 0, 0, 0, 0, 0,
                          ex(32'h2, 32'h1, 4'd0, 32'h0, 0, 0, 0, 0, 0)));
        tbl.push_back(mkv("srlv", r_ins(1, 2, 3, 0, 6'h06), 32'h3, 32'h80, 0, 0, 0, 0, 0, 0,
                          ex(32'h3, 32'h80, 4'd8, 32'h80, 3, 1, 0, 0, 0)));
        tbl.push_back(mkv("srl", r_ins(7, 2, 3, 31, 6'h02), 32'h3, 32'h80, 0, 0, 0, 0, 0, 0,
                          ex(32'd31, 32'h80, 4'd8, 32'h80, 3, 1, 0, 0, 0)));

        #3 chk("reset_async", dut_out(), 128'h0);
        @(negedge clk);
        rst = 1'b0;

        foreach (tbl[i]) begin
            drive(1'b1, tbl[i].ins, tbl[i].rsd, tbl[i].rtd);
            set_fwd(tbl[i].ew, tbl[i].ea, tbl[i].ed, tbl[i].mw, tbl[i].ma, tbl[i].md);
            step();
            chk(tbl[i].name, dut_out(), tbl[i].e);
            drive(1'b0, 32'h0, 32'h0, 32'h0);
            set_fwd(0, 0, 0, 0, 0, 0);
            step();
            chk({tbl[i].name, "_idle"}, dut_out(), 128'h0);
        end

        // load-use: lw $5 then add $6,$5,$7
        drive(1'b1, i_ins(6'h23, 1, 5, 16'h0), 32'h100, 32'h0);
        step();
        chk("lu_lw_held", out_mem_read, 1);
        drive(1'b1, r_ins(5, 7, 6, 0, 6'h20), 32'hDEAD, 32'h7);
        #1 chk("lu_ready_low", in_ready, 0);
        step();
        chk("lu_bubble", dut_out(), 128'h0);
        chk("lu_ready_back", in_ready, 1);
        set_fwd(0, 0, 0, 1, 5, 32'h5555);
        step();
        chk("lu_add_fwd", dut_out(), ex(32'h5555, 32'h7, 4'd0, 32'h7, 6, 1, 0, 0, 0));
        drive(1'b0, 32'h0, 32'h0, 32'h0);
        set_fwd(0, 0, 0, 0, 0, 0);
        step();

        // stall three cycles, then flush+stall
        drive(1'b1, i_ins(6'h08, 1, 2, 16'h0003), 32'd10, 32'h0);
        e_hold = ref_decode();
        step();
        chk("stall_load", dut_out(), e_hold);
        drive(1'b1, r_ins(3, 4, 5, 0, 6'h25), 32'h1, 32'h2);
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1 chk("stall_ready", in_ready, 0);
            step();
            chk("stall_hold", dut_out(), e_hold);
        end
        flush = 1'b1;
        step();
        chk("flush_stall", dut_out(), 128'h0);
        stall = 1'b0; flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 32'h0);
        step();

        // flush during a hazard cycle does not accept the dependent instruction
        drive(1'b1, i_ins(6'h23, 1, 5, 16'h0), 32'h100, 32'h0);
        step();
        drive(1'b1, r_ins(5, 7, 6, 0, 6'h20), 32'hDEAD, 32'h7);
        flush = 1'b1;
        #1 chk("fh_ready_low", in_ready, 0);
        step();
        chk("fh_bubble", dut_out(), 128'h0);
        flush = 1'b0;
        set_fwd(0, 0, 0, 1, 5, 32'h6666);
        #1 chk("fh_ready_back", in_ready, 1);
        step();
        chk("fh_add", dut_out(), ex(32'h6666, 32'h7, 4'd0, 32'h7, 6, 1, 0, 0, 0));
        set_fwd(0, 0, 0, 0, 0, 0);

        // async reset while stalled
        drive(1'b1, i_ins(6'h08, 1, 2, 16'h0003), 32'd10, 32'h0);
        step();
        stall = 1'b1;
        step();
        chk("rst_pre_valid", out_valid, 1);
        #2 rst = 1'b1;
        #1 chk("rst_mid_stall", dut_out(), 128'h0);
        @(negedge clk);
        rst = 1'b0; stall = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 32'h0);

        // randomized traffic against the model
        held = '0;
        for (int n = 0; n < 2000; n++) begin
            logic [31:0] ins;
            if ($urandom_range(0, 1) == 0)
                ins = r_ins($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                            $urandom_range(0, 31), r_fn[$urandom_range(0, 12)]);
            else
                ins = i_ins(i_op[$urandom_range(0, 10)], $urandom_range(0, 3),
                            $urandom_range(0, 3), 16'($urandom));
            drive($urandom_range(0, 9) < 8, ins, $urandom, $urandom);
            set_fwd($urandom_range(0, 1), $urandom_range(0, 3), $urandom,
                    $urandom_range(0, 1), $urandom_range(0, 3), $urandom);
            stall = $urandom_range(0, 99) < 15;
            flush = $urandom_range(0, 99) < 5;
            #1;
            hz = in_valid && held.valid && held.mr && held.dest != 0 &&
                 ((uses_rs(ins) && ins[25:21] == held.dest) ||
                  (uses_rt(ins) && ins[20:16] == held.dest));
            chk("rand_ready", in_ready, !stall && !hz);
            if (flush)                 held = '0;
            else if (stall)            held = held;
            else if (hz || !in_valid)  held = '0;
            else                       held = ref_decode();
            step();
            chk("rand_out", dut_out(), held);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
